// File: rtl/ver_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ver_loader_pkg
// Description : Shared types and constants for the ver_loader boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
package ver_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    ADDR      = 3'd1,
    LEN       = 3'd2,
    DATA      = 3'd3,
    WRITE     = 3'd4,
    CHECK     = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } state_t;

  localparam logic [7:0] c_MAGIC_DEFAULT = 8'hA5;
  localparam int         c_BUS_WIDTH     = 32;
  localparam int         c_STRB_WIDTH    = 4;

endpackage
`default_nettype wire

// File: rtl/ver_loader_assembler.sv
`default_nettype none
// ============================================================================
// Module      : ver_loader_assembler
// Description : Little-endian byte-to-word shift register with completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ver_loader_assembler
  import ver_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clear,
  input  logic                   i_byte_valid,
  input  logic [7:0]             i_byte,
  output logic [c_BUS_WIDTH-1:0] o_word,
  output logic                   o_word_complete
);

  logic [c_BUS_WIDTH-1:0] r_word;
  logic [1:0]             r_cnt;

  // Bytes enter at the top so the first byte ends up in bits [7:0].
  assign o_word          = {i_byte, r_word[c_BUS_WIDTH-1:8]};
  assign o_word_complete = i_byte_valid && (r_cnt == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= '0;
      r_cnt  <= 2'd0;
    end else if (i_clear) begin
      r_cnt  <= 2'd0;
    end else if (i_byte_valid) begin
      r_word <= o_word;
      r_cnt  <= r_cnt + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ver_loader.sv
`default_nettype none
// ============================================================================
// Module      : ver_loader
// Description : Framed serial image loader writing RAM over a Verbus master;
//               holds the CPU in reset until the image is in place.
//               Optional VER_LOADER_CHECKSUM_EN adds a trailing XOR byte check.
// Revision    : 1.0 - initial release
// ============================================================================
module ver_loader
  import ver_loader_pkg::*;
#(
  parameter logic [7:0] MAGIC          = c_MAGIC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    bus_valid,
  output logic [c_BUS_WIDTH-1:0]  bus_address,
  output logic [c_STRB_WIDTH-1:0] bus_wstrobe,
  output logic [c_BUS_WIDTH-1:0]  bus_wdata,
  input  logic                    bus_ready,
  output logic                    cpu_reset,
  output logic                    busy,
  output logic                    error
);

  localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t                  r_state;
  logic [7:0]              r_buf;
  logic                    r_buf_full;
  logic [31:0]             r_remaining;
  logic [31:0]             r_tmo;
  logic [c_BUS_WIDTH-1:0]  r_addr;
  logic [c_BUS_WIDTH-1:0]  r_wdata;
  logic [c_STRB_WIDTH-1:0] r_wstrobe;
  logic                    r_valid;
  logic                    r_cpu_reset;
  logic                    r_busy;
  logic                    r_error;
`ifdef VER_LOADER_CHECKSUM_EN
  logic [7:0]              r_csum;
`endif

  logic                   w_use_buf;
  logic                   w_byte_valid;
  logic [7:0]             w_byte;
  logic                   w_asm_valid;
  logic                   w_counting;
  logic                   w_timeout;
  logic [c_BUS_WIDTH-1:0] w_word;
  logic                   w_word_complete;

  // A byte parked during WRITE is drained before any live byte.
  assign w_use_buf    = r_buf_full && (r_state == DATA || r_state == CHECK);
  assign w_byte_valid = w_use_buf ||
                        (rx_valid && (r_state == ADDR || r_state == LEN ||
                                      r_state == DATA || r_state == CHECK));
  assign w_byte       = w_use_buf ? r_buf : rx_data;
  assign w_asm_valid  = w_byte_valid &&
                        (r_state == ADDR || r_state == LEN || r_state == DATA);
  assign w_counting   = (r_state == ADDR) || (r_state == LEN) || (r_state == DATA) ||
                        (r_state == WRITE) || (r_state == CHECK);
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && w_counting && !rx_valid &&
                        !r_valid && (r_tmo == c_TMO_LAST);

  ver_loader_assembler u_assembler (
    .clk             (clk),
    .reset           (reset),
    .i_clear         (r_state == WAIT_SYNC),
    .i_byte_valid    (w_asm_valid),
    .i_byte          (w_byte),
    .o_word          (w_word),
    .o_word_complete (w_word_complete)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= WAIT_SYNC;
      r_buf       <= 8'h00;
      r_buf_full  <= 1'b0;
      r_remaining <= 32'd0;
      r_tmo       <= 32'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrobe   <= '0;
      r_valid     <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
`ifdef VER_LOADER_CHECKSUM_EN
      r_csum      <= 8'h00;
`endif
    end else begin
      case (r_state)
        WAIT_SYNC: begin
          if (rx_valid && rx_data == MAGIC) begin
            r_state <= ADDR;
            r_busy  <= 1'b1;
`ifdef VER_LOADER_CHECKSUM_EN
            r_csum  <= 8'h00;
`endif
          end
        end
        ADDR: begin
          if (w_word_complete) begin
            r_addr  <= {w_word[c_BUS_WIDTH-1:2], 2'b00};
            r_state <= LEN;
          end
        end
        LEN: begin
          if (w_word_complete) begin
            r_remaining <= w_word;
            if (w_word != 32'd0) begin
              r_state <= DATA;
            end else begin
`ifdef VER_LOADER_CHECKSUM_EN
              r_state <= CHECK;
`else
              r_state     <= DONE;
              r_busy      <= 1'b0;
              r_cpu_reset <= 1'b0;
`endif
            end
          end
        end
        DATA: begin
`ifdef VER_LOADER_CHECKSUM_EN
          if (w_byte_valid) r_csum <= r_csum ^ w_byte;
`endif
          if (w_word_complete) begin
            r_wdata   <= w_word;
            r_valid   <= 1'b1;
            r_wstrobe <= {c_STRB_WIDTH{1'b1}};
            r_state   <= WRITE;
          end
        end
        WRITE: begin
          if (bus_ready) begin
            r_valid     <= 1'b0;
            r_wstrobe   <= '0;
            r_addr      <= r_addr + 32'd4;
            r_remaining <= r_remaining - 32'd1;
            if (r_remaining > 32'd1) begin
              r_state <= DATA;
            end else begin
`ifdef VER_LOADER_CHECKSUM_EN
              r_state <= CHECK;
`else
              r_state     <= DONE;
              r_busy      <= 1'b0;
              r_cpu_reset <= 1'b0;
`endif
            end
          end
        end
`ifdef VER_LOADER_CHECKSUM_EN
        CHECK: begin
          if (w_byte_valid) begin
            r_busy <= 1'b0;
            if (w_byte == r_csum) begin
              r_state     <= DONE;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase

      // Byte buffer; a second byte while full is an overflow and overrides
      // whatever the handshake above decided.
      if (r_state == WRITE && rx_valid) begin
        if (r_buf_full) begin
          r_state     <= ERROR;
          r_error     <= 1'b1;
          r_busy      <= 1'b0;
          r_cpu_reset <= 1'b1;
          r_valid     <= 1'b0;
          r_wstrobe   <= '0;
        end else begin
          r_buf      <= rx_data;
          r_buf_full <= 1'b1;
        end
      end else if (w_use_buf) begin
        if (rx_valid) r_buf <= rx_data;
        else          r_buf_full <= 1'b0;
      end

      if (w_counting) begin
        if (rx_valid)      r_tmo <= 32'd0;
        else if (!r_valid) r_tmo <= r_tmo + 32'd1;
      end else begin
        r_tmo <= 32'd0;
      end

      if (w_timeout) begin
        r_state     <= ERROR;
        r_error     <= 1'b1;
        r_busy      <= 1'b0;
        r_cpu_reset <= 1'b1;
        r_valid     <= 1'b0;
        r_wstrobe   <= '0;
      end
    end
  end

  assign bus_valid   = r_valid;
  assign bus_address = r_addr;
  assign bus_wstrobe = r_wstrobe;
  assign bus_wdata   = r_wdata;
  assign cpu_reset   = r_cpu_reset;
  assign busy        = r_busy;
  assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ver_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ver_loader
// Description : Self-checking bench for ver_loader (TIMEOUT_CYCLES = 50).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ver_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        bus_valid;
  logic [31:0] bus_address;
  logic [3:0]  bus_wstrobe;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic        cpu_reset;
  logic        busy;
  logic        error;

  int total = 0;
  int bad   = 0;
  int gap_max = 0;
  bit glitch  = 0;

  ver_loader #(.MAGIC(8'hA5), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .bus_valid(bus_valid), .bus_address(bus_address), .bus_wstrobe(bus_wstrobe),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .cpu_reset(cpu_reset),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b0; bus_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    if (glitch && !bus_valid) bus_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    rx_valid = 1'b0; bus_ready = 1'b0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [31:0] a, input logic [31:0] n);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_trailer(input logic [7:0] cs);
`ifdef VER_LOADER_CHECKSUM_EN
    send_byte(cs);
`else
    if (cs == 8'h00) ; // no trailer byte in this build
`endif
  endtask

  // Waits for a write request, stalls it `delay` cycles, optionally injects a
  // byte at stall step inj_at, and reports what was presented on the bus.
  task automatic capture(input int delay, input bit inject, input logic [7:0] ib,
                         input int inj_at, output logic [31:0] a,
                         output logic [31:0] d, output bit stable, output bit ok);
    ok = 0; stable = 1; a = '0; d = '0;
    for (int i = 0; i < 300; i++) begin
      if (bus_valid) break;
      @(negedge clk);
    end
    if (!bus_valid) return;
    a = bus_address; d = bus_wdata;
    for (int i = 0; i <= delay; i++) begin
      rx_valid = 1'b0;
      if (inject && i == inj_at) begin rx_valid = 1'b1; rx_data = ib; end
      bus_ready = (i == delay);
      if (bus_valid !== 1'b1 || bus_address !== a || bus_wdata !== d ||
          bus_wstrobe !== 4'hF) stable = 0;
      @(negedge clk);
    end
    rx_valid = 1'b0; bus_ready = 1'b0;
    if (bus_valid !== 1'b0) stable = 0;
    ok = 1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus_valid); end
    total++; if (bus_address !== 32'h0 || bus_wdata !== 32'h0 || bus_wstrobe !== 4'h0) begin
      bad++; $display("FAIL reset_bus got=%h/%h/%h exp=0", bus_address, bus_wdata, bus_wstrobe); end
    total++; if ({cpu_reset, busy, error} !== 3'b100) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=100", {cpu_reset, busy, error}); end
  endtask

  task automatic test_basic();
    logic [31:0] a, d; bit st, ok;
    logic [31:0] ea [2] = '{32'h00001000, 32'h00001004};
    logic [31:0] ed [2] = '{32'h44332211, 32'h88776655};
    do_reset();
    send_hdr(32'h00001000, 32'd2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
    for (int w = 0; w < 2; w++) begin
      send_word(ed[w]);
      capture(0, 0, 8'h00, 0, a, d, st, ok);
      total++; if (!ok || a !== ea[w] || d !== ed[w]) begin
        bad++; $display("FAIL basic_write%0d got=%h@%h ok=%0d exp=%h@%h", w, d, a, ok, ed[w], ea[w]); end
      if (w == 0) begin
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL basic_cpu_hold got=%b exp=1", cpu_reset); end
      end
    end
    send_trailer(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88);
    total++; if ({cpu_reset, busy, error} !== 3'b000) begin
      bad++; $display("FAIL basic_done got=%b exp=000", {cpu_reset, busy, error}); end
  endtask

  task automatic test_stall();
    logic [31:0] a, d; bit st, ok; int extra;
    logic [31:0] ed [2] = '{32'h44332211, 32'h88776655};
    do_reset();
    send_hdr(32'h00001000, 32'd2);
    for (int w = 0; w < 2; w++) begin
      send_word(ed[w]);
      capture(5, 0, 8'h00, 0, a, d, st, ok);
      total++; if (!ok || !st || a !== 32'h1000 + 32'(4*w) || d !== ed[w]) begin
        bad++; $display("FAIL stall_write%0d got=%h@%h stable=%0d exp=%h@%h", w, d, a, st, ed[w], 32'h1000 + 32'(4*w)); end
    end
    send_trailer(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88);
    extra = 0;
    repeat (10) begin @(negedge clk); if (bus_valid) extra++; end
    total++; if (extra != 0 || cpu_reset !== 1'b0) begin
      bad++; $display("FAIL stall_count extra=%0d cpu_reset=%b exp=0/0", extra, cpu_reset); end
  endtask

  task automatic test_garbage_zero();
    int seen = 0;
    do_reset();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL garbage_busy got=%b exp=0", busy); end
    send_hdr(32'h00000003, 32'd0);
    send_trailer(8'h00);
    total++; if (cpu_reset !== 1'b0 || busy !== 1'b0 || bus_address !== 32'h0) begin
      bad++; $display("FAIL zero_done cpu_reset=%b busy=%b addr=%h exp=0/0/0", cpu_reset, busy, bus_address); end
    send_hdr(32'h00000100, 32'd1);
    send_word(32'hDEADBEEF);
    repeat (5) begin @(negedge clk); if (bus_valid) seen++; end
    total++; if (seen != 0 || busy !== 1'b0 || cpu_reset !== 1'b0) begin
      bad++; $display("FAIL done_ignores writes=%0d busy=%b cpu_reset=%b exp=0/0/0", seen, busy, cpu_reset); end
  endtask

  task automatic test_wrap();
    logic [31:0] a, d, w0, w1; bit st, ok;
    do_reset();
    w0 = $urandom; w1 = $urandom;
    send_hdr(32'hFFFFFFFC, 32'd2);
    send_word(w0);
    capture(1, 0, 8'h00, 0, a, d, st, ok);
    total++; if (!ok || a !== 32'hFFFFFFFC || d !== w0) begin
      bad++; $display("FAIL wrap_first got=%h@%h exp=%h@fffffffc", d, a, w0); end
    send_word(w1);
    capture(1, 0, 8'h00, 0, a, d, st, ok);
    total++; if (!ok || a !== 32'h0 || d !== w1) begin
      bad++; $display("FAIL wrap_second got=%h@%h exp=%h@00000000", d, a, w1); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_hdr(32'h00000200, 32'd2);
    send_word(32'h01020304);
    for (int i = 0; i < 100 && !bus_valid; i++) @(negedge clk);
    total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL ovf_req got=%b exp=1", bus_valid); end
    send_byte(8'h01);
    send_byte(8'h02);
    total++; if ({error, cpu_reset, bus_valid, busy} !== 4'b1100) begin
      bad++; $display("FAIL ovf_error got=%b exp=1100", {error, cpu_reset, bus_valid, busy}); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    send_hdr(32'h00000300, 32'd1);
    send_word(32'hCAFEF00D);
    for (int i = 0; i < 100 && !bus_valid; i++) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (bus_valid !== 1'b0 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
      bad++; $display("FAIL midreset got=%b%b%b exp=001", bus_valid, busy, cpu_reset); end
    @(negedge clk); reset = 1'b0; @(negedge clk);
    send_word(32'hCAFEF00D);
    total++; if (busy !== 1'b0 || bus_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_noresume busy=%b valid=%b exp=0/0", busy, bus_valid); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h20);
    repeat (49) @(negedge clk);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b exp=0", error); end
    @(negedge clk);
    total++; if (error !== 1'b1 || cpu_reset !== 1'b1) begin
      bad++; $display("FAIL tmo_fire err=%b cpu_reset=%b exp=1/1", error, cpu_reset); end
  endtask

`ifdef VER_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    logic [31:0] a, d; bit st, ok;
    do_reset();
    send_hdr(32'h00000040, 32'd1);
    send_word(32'h04030201);
    capture(0, 0, 8'h00, 0, a, d, st, ok);
    send_byte(8'h04 ^ 8'h03 ^ 8'h02 ^ 8'h01 ^ 8'hFF);
    total++; if (error !== 1'b1 || cpu_reset !== 1'b1) begin
      bad++; $display("FAIL csum_bad err=%b cpu_reset=%b exp=1/1", error, cpu_reset); end
  endtask
`endif

  task automatic test_random();
    logic [7:0]  q [$];
    logic [31:0] base, a, d, exp_a, exp_d;
    logic [7:0]  cs, nb;
    bit st, ok, inj, trailer_sent;
    int n, idx, dly;
    gap_max = 3; glitch = 1;
    for (int it = 0; it < 16; it++) begin
      do_reset();
      base = $urandom; n = $urandom_range(1, 4);
      q.delete(); cs = 8'h00;
      for (int i = 0; i < 4*n; i++) begin q.push_back(8'($urandom)); cs ^= q[i]; end
      send_hdr(base, 32'(n));
      idx = 0; trailer_sent = 0;
      for (int w = 0; w < n; w++) begin
        while (idx < 4*w + 4) begin send_byte(q[idx]); idx++; end
        dly = (w == 0 && it % 4 == 0) ? 60 : $urandom_range(0, 6);
        inj = 1'($urandom_range(0, 1));
`ifdef VER_LOADER_CHECKSUM_EN
        nb = (w < n-1) ? q[idx] : cs;
`else
        nb = (w < n-1) ? q[idx] : 8'h5A;
`endif
        capture(dly, inj, nb, $urandom_range(0, dly), a, d, st, ok);
        if (inj && w < n-1) idx++;
        if (inj && w == n-1) trailer_sent = 1;
        exp_a = (base & 32'hFFFFFFFC) + 32'(4*w);
        exp_d = {q[4*w+3], q[4*w+2], q[4*w+1], q[4*w]};
        total++; if (!ok || !st || a !== exp_a || d !== exp_d) begin
          bad++; $display("FAIL rand%0d_w%0d got=%h@%h ok=%0d st=%0d exp=%h@%h", it, w, d, a, ok, st, exp_d, exp_a); end
      end
      if (!trailer_sent) send_trailer(cs);
      repeat (2) @(negedge clk);
      total++; if ({cpu_reset, busy, error} !== 3'b000) begin
        bad++; $display("FAIL rand%0d_done got=%b exp=000", it, {cpu_reset, busy, error}); end
    end
    gap_max = 0; glitch = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_garbage_zero();
    test_wrap();
    test_overflow();
    test_reset_mid_write();
    test_timeout();
`ifdef VER_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
`default_nettype wire
